// File: rtl/execute_divide_sequencer.sv
// Iterative RV32M divide unit (DIV/DIVU/REM/REMU): 32-step restoring division with sign fix-up.
// Define DIVIDE_EARLY_OUT_EN to finish divide-by-zero and signed-overflow requests one cycle after accept.
module execute_divide_sequencer #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid_in,
  output logic            req_ready_out,
  input  logic [1:0]      op_in,
  input  logic [XLEN-1:0] dividend_in,
  input  logic [XLEN-1:0] divisor_in,
  input  logic [4:0]      rd_in,
  input  logic            flush_in,
  output logic            busy_out,
  output logic            result_valid_out,
  input  logic            result_ready_in,
  output logic [XLEN-1:0] result_out,
  output logic [4:0]      rd_out
);

  localparam int unsigned     CntW    = $clog2(XLEN);
  localparam logic [CntW-1:0] CntLoad = CntW'(XLEN - 1);
  localparam logic [XLEN-1:0] MinNeg  = {1'b1, {(XLEN - 1){1'b0}}};

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StPrep = 3'd1;
  localparam logic [2:0] StIter = 3'd2;
  localparam logic [2:0] StFix  = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  // op[0] set means unsigned, op[1] set means remainder.
  function automatic logic is_special(input logic [1:0] op, input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
    return (b == '0) || (!op[0] && (a == MinNeg) && (b == '1));
  endfunction

  function automatic logic [XLEN-1:0] special_result(input logic [1:0] op,
                                                     input logic [XLEN-1:0] a,
                                                     input logic [XLEN-1:0] b);
    if (b == '0) return op[1] ? a : '1;
    return op[1] ? '0 : MinNeg;
  endfunction

  logic [2:0]      state_q, state_d;
  logic [1:0]      op_q;
  logic [XLEN-1:0] dividend_q, divisor_q;
  logic [4:0]      rd_tag_q;
  logic            special_q;
  logic [XLEN-1:0] quot_q, rem_q, dvsr_q;
  logic [CntW-1:0] cnt_q;
  logic            neg_quot_q, neg_rem_q;
  logic [XLEN-1:0] result_q;
  logic [4:0]      rd_q;

  logic            accept, special_in;
  logic            a_neg, b_neg;
  logic [XLEN:0]   shift_rem;
  logic            ge;
  logic [XLEN-1:0] trial;
  logic [XLEN-1:0] quot_fix, rem_fix, fix_result;

  assign req_ready_out    = (state_q == StIdle) && !rst && !flush_in;
  assign busy_out         = (state_q != StIdle);
  assign result_valid_out = (state_q == StDone);
  assign result_out       = result_q;
  assign rd_out           = rd_q;

  assign accept     = req_valid_in && req_ready_out;
  assign special_in = is_special(op_in, dividend_in, divisor_in);

  assign a_neg = !op_q[0] && dividend_q[XLEN-1];
  assign b_neg = !op_q[0] && divisor_q[XLEN-1];

  // rem stays below dvsr, so the shifted value is below 2*dvsr and the difference fits XLEN bits.
  assign shift_rem = {rem_q, quot_q[XLEN-1]};
  assign ge        = shift_rem >= {1'b0, dvsr_q};
  assign trial     = shift_rem[XLEN-1:0] - dvsr_q;

  assign quot_fix   = neg_quot_q ? -quot_q : quot_q;
  assign rem_fix    = neg_rem_q ? -rem_q : rem_q;
  assign fix_result = special_q ? special_result(op_q, dividend_q, divisor_q)
                                : (op_q[1] ? rem_fix : quot_fix);

  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
`ifdef DIVIDE_EARLY_OUT_EN
          state_d = special_in ? StDone : StPrep;
`else
          state_d = StPrep;
`endif
        end
      end
      StPrep:  state_d = StIter;
      StIter:  if (cnt_q == '0) state_d = StFix;
      StFix:   state_d = StDone;
      StDone:  if (result_ready_in) state_d = StIdle;
      default: state_d = StIdle;
    endcase
    if (flush_in) state_d = StIdle;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= StIdle;
    else     state_q <= state_d;
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      op_q       <= op_in;
      dividend_q <= dividend_in;
      divisor_q  <= divisor_in;
      rd_tag_q   <= rd_in;
      special_q  <= special_in;
    end
    case (state_q)
      StPrep: begin
        quot_q     <= a_neg ? -dividend_q : dividend_q;
        dvsr_q     <= b_neg ? -divisor_q : divisor_q;
        rem_q      <= '0;
        cnt_q      <= CntLoad;
        neg_quot_q <= a_neg ^ b_neg;
        neg_rem_q  <= a_neg;
      end
      StIter: begin
        rem_q  <= ge ? trial : shift_rem[XLEN-1:0];
        quot_q <= {quot_q[XLEN-2:0], ge};
        if (cnt_q != '0) cnt_q <= cnt_q - CntW'(1);
      end
      default: ;
    endcase
  end

  // Result and tag only move on entry to DONE; a flush leaves the previous values in place.
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      rd_q     <= '0;
    end else if (!flush_in) begin
      if (state_q == StFix) begin
        result_q <= fix_result;
        rd_q     <= rd_tag_q;
      end
`ifdef DIVIDE_EARLY_OUT_EN
      if (accept && special_in) begin
        result_q <= special_result(op_in, dividend_in, divisor_in);
        rd_q     <= rd_in;
      end
`endif
    end
  end

endmodule

// File: tb/tb_execute_divide_sequencer.sv
// Self-checking bench for execute_divide_sequencer: directed cases plus random divides
// against an arithmetic reference model.
module tb_execute_divide_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid_in;
  logic        req_ready_out;
  logic [1:0]  op_in;
  logic [31:0] dividend_in;
  logic [31:0] divisor_in;
  logic [4:0]  rd_in;
  logic        flush_in;
  logic        busy_out;
  logic        result_valid_out;
  logic        result_ready_in;
  logic [31:0] result_out;
  logic [4:0]  rd_out;

  int n_checks = 0;
  int n_fail   = 0;

  execute_divide_sequencer #(.XLEN(32)) dut (
    .clk              (clk),
    .rst              (rst),
    .req_valid_in     (req_valid_in),
    .req_ready_out    (req_ready_out),
    .op_in            (op_in),
    .dividend_in      (dividend_in),
    .divisor_in       (divisor_in),
    .rd_in            (rd_in),
    .flush_in         (flush_in),
    .busy_out         (busy_out),
    .result_valid_out (result_valid_out),
    .result_ready_in  (result_ready_in),
    .result_out       (result_out),
    .rd_out           (rd_out)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RISC-V divide semantics from plain arithmetic.
  function automatic logic [31:0] ref_div(input logic [1:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic is_signed;
    logic is_rem;
    int   sa;
    int   sb;
    is_signed = !op[0];
    is_rem    = op[1];
    if (b == 32'd0) return is_rem ? a : 32'hFFFF_FFFF;
    if (is_signed && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
      return is_rem ? 32'd0 : 32'h8000_0000;
    if (is_signed) begin
      sa = $signed(a);
      sb = $signed(b);
      return is_rem ? 32'(sa % sb) : 32'(sa / sb);
    end
    return is_rem ? a % b : a / b;
  endfunction

  // Samples counted after each edge, the accept edge giving sample 1:
  // PREP, 32 ITER, FIX, then DONE is seen at sample 35.
  function automatic int ref_lat(input logic [1:0] op, input logic [31:0] a,
                                 input logic [31:0] b);
    logic special;
    special = (b == 32'd0) || (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF);
`ifdef DIVIDE_EARLY_OUT_EN
    if (special) return 1;
`endif
    if (special) return 35;
    return 35;
  endfunction

  task automatic run_div(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input int hold, input string tag);
    logic [31:0] exp;
    int          lat;
    int          busy_low;
    exp = ref_div(op, a, b);
    @(negedge clk);
    req_valid_in    = 1'b1;
    op_in           = op;
    dividend_in     = a;
    divisor_in      = b;
    rd_in           = rd;
    result_ready_in = (hold == 0);
    #1;
    check({tag, "_req_ready"}, 32'(req_ready_out), 32'd1);
    @(posedge clk);
    #1;
    // Scramble inputs to prove operands and tag were captured at accept.
    req_valid_in = 1'b0;
    dividend_in  = $urandom;
    divisor_in   = $urandom;
    rd_in        = 5'($urandom);
    op_in        = 2'($urandom);
    lat      = 1;
    busy_low = 0;
    while (!result_valid_out && lat < 60) begin
      if (!busy_out) busy_low++;
      @(posedge clk);
      #1;
      lat++;
    end
    check({tag, "_latency"}, 32'(lat), 32'(ref_lat(op, a, b)));
    check({tag, "_result"}, result_out, exp);
    check({tag, "_rd"}, 32'(rd_out), 32'(rd));
    check({tag, "_busy_gap"}, 32'(busy_low), 32'd0);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, "_hold_valid"}, 32'(result_valid_out), 32'd1);
      check({tag, "_hold_result"}, result_out, exp);
      check({tag, "_hold_rd"}, 32'(rd_out), 32'(rd));
      check({tag, "_hold_req_ready"}, 32'(req_ready_out), 32'd0);
    end
    result_ready_in = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_idle_valid"}, 32'(result_valid_out), 32'd0);
    check({tag, "_idle_busy"}, 32'(busy_out), 32'd0);
    check({tag, "_idle_req_ready"}, 32'(req_ready_out), 32'd1);
    check({tag, "_idle_keeps_result"}, result_out, exp);
  endtask

  initial begin
    int          valid_seen;
    logic [1:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;
    int          sel;

    rst             = 1'b1;
    req_valid_in    = 1'b0;
    op_in           = 2'd0;
    dividend_in     = 32'd0;
    divisor_in      = 32'd0;
    rd_in           = 5'd0;
    flush_in        = 1'b0;
    result_ready_in = 1'b1;

    repeat (3) @(posedge clk);
    #1;
    check("reset_req_ready", 32'(req_ready_out), 32'd0);
    check("reset_busy", 32'(busy_out), 32'd0);
    check("reset_valid", 32'(result_valid_out), 32'd0);
    check("reset_result", result_out, 32'd0);
    check("reset_rd", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("post_reset_req_ready", 32'(req_ready_out), 32'd1);

    run_div(2'd1, 32'd100, 32'd7, 5'd3, 0, "divu_100_7");
    run_div(2'd3, 32'd100, 32'd7, 5'd4, 0, "remu_100_7");
    run_div(2'd0, 32'hFFFF_FFF9, 32'd2, 5'd5, 0, "div_m7_2");
    run_div(2'd2, 32'hFFFF_FFF9, 32'd2, 5'd6, 0, "rem_m7_2");
    run_div(2'd1, 32'hFFFF_FFF9, 32'd2, 5'd7, 0, "divu_big_2");
    run_div(2'd1, 32'd5, 32'd0, 5'd8, 0, "divu_by_zero");
    run_div(2'd2, 32'd5, 32'd0, 5'd9, 0, "rem_by_zero");
    run_div(2'd0, 32'hFFFF_FFF9, 32'd0, 5'd10, 0, "div_neg_by_zero");
    run_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 0, "div_overflow");
    run_div(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 0, "rem_overflow");
    run_div(2'd1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 0, "divu_no_overflow");

    // Flush during ITER cycle 10 (sample 11 after accept).
    @(negedge clk);
    req_valid_in = 1'b1;
    op_in        = 2'd1;
    dividend_in  = 32'd1000;
    divisor_in   = 32'd3;
    rd_in        = 5'd14;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check("flush_busy_before", 32'(busy_out), 32'd1);
    flush_in = 1'b1;
    #1;
    check("flush_req_ready_low", 32'(req_ready_out), 32'd0);
    @(posedge clk);
    #1;
    flush_in = 1'b0;
    #1;
    check("flush_busy_after", 32'(busy_out), 32'd0);
    check("flush_req_ready_after", 32'(req_ready_out), 32'd1);
    valid_seen = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_valid_out) valid_seen++;
      @(posedge clk);
      #1;
    end
    check("flush_no_valid", 32'(valid_seen), 32'd0);
    run_div(2'd1, 32'd9, 32'd3, 5'd21, 0, "after_flush");

    // Flush wins over an accept in the same cycle.
    @(negedge clk);
    req_valid_in = 1'b1;
    flush_in     = 1'b1;
    #1;
    check("flush_accept_req_ready", 32'(req_ready_out), 32'd0);
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    flush_in     = 1'b0;
    check("flush_accept_busy", 32'(busy_out), 32'd0);

    run_div(2'd1, 32'd12345, 32'd67, 5'd9, 5, "backpressure");
    run_div(2'd0, 32'h8000_0000, 32'hFFFF_FFFF, 5'd30, 3, "backpressure_special");

    // Reset mid-operation clears state and zeroes result and tag.
    @(negedge clk);
    req_valid_in = 1'b1;
    op_in        = 2'd1;
    dividend_in  = 32'd50;
    divisor_in   = 32'd5;
    rd_in        = 5'd17;
    @(posedge clk);
    #1;
    req_valid_in = 1'b0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    check("midrst_busy", 32'(busy_out), 32'd0);
    check("midrst_valid", 32'(result_valid_out), 32'd0);
    check("midrst_result", result_out, 32'd0);
    check("midrst_rd", 32'(rd_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    for (int n = 0; n < 24; n++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = $urandom;
      sel = $urandom_range(0, 7);
      case (sel)
        0:       rb = 32'd0;
        1: begin
          ra = 32'h8000_0000;
          rb = 32'hFFFF_FFFF;
        end
        2:       rb = $urandom_range(1, 15);
        3:       rb = -($urandom_range(1, 15));
        default: rb = $urandom;
      endcase
      run_div(rop, ra, rb, 5'($urandom), $urandom_range(0, 2), "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
